// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame geometry and
// common keyboard command bytes.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_LEN = 11;
  localparam int unsigned PS2_EDGE_W    = 4;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_IDLE,
    ST_DONE
  } ps2_tx_state_e;

  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } ps2_tx_byte_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe
// derived from consecutive synchronized samples.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic fall_c
);

  logic meta;
  logic prev;

  // Lines idle high, so everything resets to 1 and no edge appears at reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall_c = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts out one byte with odd parity on device clock edges and reports ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout,
  output logic       busy
);

  localparam int unsigned INH_CYCLES = (CLK_HZ / 1_000_000) * INHIBIT_US;
  localparam int unsigned WD_CYCLES  = (CLK_HZ / 1000) * TIMEOUT_MS;
  localparam int unsigned INH_W      = (INH_CYCLES > 1) ? $clog2(INH_CYCLES) : 1;
  localparam int unsigned WD_W       = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;

  localparam logic [INH_W-1:0]      INH_LAST  = INH_W'(INH_CYCLES - 1);
  localparam logic [WD_W-1:0]       WD_LAST   = WD_W'(WD_CYCLES - 1);
  localparam logic [PS2_EDGE_W-1:0] EDGE_PAR  = PS2_EDGE_W'(PS2_FRAME_LEN - 2);
  localparam logic [PS2_EDGE_W-1:0] EDGE_ACK  = PS2_EDGE_W'(PS2_FRAME_LEN);
  localparam logic [PS2_EDGE_W-1:0] EDGE_LAST_DATA = PS2_EDGE_W'(8);

  ps2_tx_state_e          state_q, state_d;
  logic [PS2_EDGE_W-1:0]  edge_q, edge_d;
  logic [INH_W-1:0]       inh_q, inh_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  ps2_tx_byte_t           frame_q, frame_d;
  logic                   ack_q, ack_d;
  logic                   to_q, to_d;

  logic clk_oe_d, data_oe_d, tx_ready_d, done_d, ack_ok_d, timeout_d;

  logic clk_sync, clk_fall;
  logic data_sync, unused_data_fall;

  ps2_sync_edge u_sync_clk (
    .clk    (clk),
    .reset  (reset),
    .din    (ps2_clk_in),
    .sync   (clk_sync),
    .fall_c (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk    (clk),
    .reset  (reset),
    .din    (ps2_data_in),
    .sync   (data_sync),
    .fall_c (unused_data_fall)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      edge_q      <= '0;
      inh_q       <= '0;
      wd_q        <= WD_LAST;
      frame_q     <= '0;
      ack_q       <= 1'b0;
      to_q        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      inh_q       <= inh_d;
      wd_q        <= wd_d;
      frame_q     <= frame_d;
      ack_q       <= ack_d;
      to_q        <= to_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      tx_ready    <= tx_ready_d;
      busy        <= ~tx_ready_d;
      done        <= done_d;
      ack_ok      <= ack_ok_d;
      timeout     <= timeout_d;
    end
  end

  // Next state, counters and the output values for the coming cycle.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    inh_d     = inh_q;
    frame_d   = frame_q;
    ack_d     = ack_q;
    to_d      = to_q;
    wd_d      = wd_q;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        inh_d = '0;
        if (tx_valid && tx_ready) begin
          frame_d.data   = tx_data;
          frame_d.parity = odd_parity(tx_data);
          edge_d         = '0;
          ack_d          = 1'b0;
          to_d           = 1'b0;
          state_d        = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_q == INH_LAST) state_d = ST_START;
        else                   inh_d   = inh_q + 1'b1;
      end
      ST_START: state_d = ST_SEND;
      ST_SEND: begin
        if (clk_fall) begin
          edge_d = edge_q + 1'b1;
          if (edge_q == EDGE_PAR) state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (clk_fall) begin
          if (edge_q != EDGE_ACK) edge_d = edge_q + 1'b1;
          ack_d   = ~data_sync;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: if (clk_sync && data_sync) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // No progress for the full watchdog window: abandon through DONE as a NACK.
    if (state_q != ST_IDLE && state_q != ST_DONE && wd_q == '0 && !clk_fall) begin
      state_d = ST_DONE;
      ack_d   = 1'b0;
      to_d    = 1'b1;
    end

    if (state_q == ST_IDLE || state_d != state_q || clk_fall) wd_d = WD_LAST;
    else                                                      wd_d = wd_q - 1'b1;

    // Edge n (1..8) puts data bit n-1 on the line, edge 9 parity, edge 10 stop.
    case (state_d)
      ST_INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = (inh_d == INH_LAST);
      end
      ST_START: data_oe_d = 1'b1;
      ST_SEND: begin
        if (edge_d == '0)                  data_oe_d = 1'b1;
        else if (edge_d <= EDGE_LAST_DATA) data_oe_d = ~frame_d.data[3'(edge_d - 4'd1)];
        else if (edge_d == EDGE_PAR)       data_oe_d = ~frame_d.parity;
      end
      default: ;
    endcase

    tx_ready_d = (state_d == ST_IDLE);
    done_d     = (state_d == ST_DONE);
    ack_ok_d   = (state_d == ST_DONE) && ack_d;
    timeout_d  = (state_d == ST_DONE) && to_d;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector line model with a 12 kHz device,
// table-driven and random frames, plus reset, busy and timeout sequences.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH_CYC = 200;    // 2 MHz * 100 us
  localparam int TO_CYC  = 2000;   // 2 MHz * 1 ms
  localparam int H       = 83;     // half period of a 12 kHz device clock at 2 MHz
  localparam int DEF_INH = 10_000; // default parameters: 100 MHz * 100 us

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tx_valid, tx_ready, clk_oe, data_oe, done, ack_ok, timeout, busy;
  logic [7:0] tx_data;
  logic       dev_clk, dev_data, line_clk, line_data;

  assign line_clk  = dev_clk & ~clk_oe;
  assign line_data = dev_data & ~data_oe;

  ps2_host_tx #(.CLK_HZ(2_000_000), .INHIBIT_US(100), .TIMEOUT_MS(1)) dut (
    .clk(clk), .reset(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(line_clk), .ps2_data_in(line_data), .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe),
    .done(done), .ack_ok(ack_ok), .timeout(timeout), .busy(busy)
  );

  logic       rst_def, tx_valid_def, d_ready, d_clk_oe, d_data_oe, d_done, d_ack, d_to, d_busy;
  logic [7:0] tx_data_def;

  ps2_host_tx dut_def (
    .clk(clk), .reset(rst_def), .tx_data(tx_data_def), .tx_valid(tx_valid_def), .tx_ready(d_ready),
    .ps2_clk_in(~d_clk_oe), .ps2_data_in(~d_data_oe), .ps2_clk_oe(d_clk_oe), .ps2_data_oe(d_data_oe),
    .done(d_done), .ack_ok(d_ack), .timeout(d_to), .busy(d_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic last_ack, last_to, last_coe, last_doe;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      last_ack <= ack_ok;
      last_to  <= timeout;
      last_coe <= clk_oe;
      last_doe <= data_oe;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Device side: waits for request-to-send, clocks the frame in, then ACKs or not.
  task automatic device(input bit clocks, input bit ack, input int abort_at,
                        output logic [10:0] frame, output bit seen);
    int n;
    frame = '0;
    seen  = 1'b0;
    n     = 0;
    while (!(clk_oe == 1'b0 && data_oe == 1'b1)) begin
      @(negedge clk);
      n++;
      if (n > 3000) return;
    end
    seen = 1'b1;
    if (!clocks) return;
    repeat (H) @(negedge clk);
    frame[0] = line_data;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      frame[k] = line_data;
      if (k == abort_at) begin
        check("pre_reset_data_oe", 32'(data_oe), 32'(1));
        rst_n = 1'b0;
        #1;
        check("reset_clk_oe", 32'(clk_oe), 32'(0));
        check("reset_data_oe", 32'(data_oe), 32'(0));
        dev_clk = 1'b1;
        return;
      end
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    dev_data = ~ack;
    repeat (4) @(negedge clk);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    repeat (4) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic transfer(input logic [7:0] d, input bit clocks, input bit ack, input bit poke,
                          input bit exp_ack, input bit exp_to);
    logic [10:0] frame;
    bit          seen;
    int          base, n, t0, lat, extra;
    n = 0;
    while (!tx_ready) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        check("ready_wait", 32'(tx_ready), 32'(1));
        return;
      end
    end
    base     = done_cnt;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    t0       = cyc;
    tx_valid = 1'b0;
    check("accept_busy", 32'(busy), 32'(1));
    tx_data = 8'($urandom);
    if (poke) begin
      fork
        device(clocks, ack, 0, frame, seen);
        begin
          repeat (600) @(negedge clk);
          tx_data  = 8'h55;
          tx_valid = 1'b1;
          repeat (3) @(negedge clk);
          tx_valid = 1'b0;
        end
      join
    end else begin
      device(clocks, ack, 0, frame, seen);
    end
    check("rts_seen", 32'(seen), 32'(1));
    n = 0;
    while (done_cnt == base && n < TO_CYC + 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", 32'(done_cnt - base), 32'(1));
    if (clocks) check("frame", 32'(frame), 32'(exp_frame(d)));
    check("ack_ok", 32'(last_ack), 32'(exp_ack));
    check("timeout", 32'(last_to), 32'(exp_to));
    check("done_clk_oe", 32'(last_coe), 32'(0));
    check("done_data_oe", 32'(last_doe), 32'(0));
    check("ready_after_done", 32'(tx_ready), 32'(1));
    if (exp_to) begin
      lat = done_cyc - t0;
      check("timeout_latency", 32'(lat >= TO_CYC && lat <= TO_CYC + INH_CYC + 40), 32'(1));
    end
    extra = 0;
    repeat (poke ? 300 : 20) begin
      @(negedge clk);
      if (clk_oe || !tx_ready) extra++;
    end
    check("single_done", 32'(done_cnt - base), 32'(1));
    if (poke) check("busy_request_dropped", 32'(extra), 32'(0));
  endtask

  typedef struct {
    logic [7:0] data;
    bit         clocks;
    bit         ack;
    bit         exp_ack;
    bit         exp_to;
  } vec_t;

  initial begin
    #2ms;
    $display("FAIL global_time_limit: actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t        vecs[4];
    logic [10:0] frame;
    bit          seen;
    int          base, n, first_doe, changes;
    logic [7:0]  d;
    bit          a;

    vecs[0] = '{data: PS2_CMD_SET_LEDS, clocks: 1, ack: 1, exp_ack: 1, exp_to: 0};
    vecs[1] = '{data: 8'h00,            clocks: 1, ack: 0, exp_ack: 0, exp_to: 0};
    vecs[2] = '{data: PS2_CMD_RESET,    clocks: 0, ack: 0, exp_ack: 0, exp_to: 1};
    vecs[3] = '{data: 8'hA5,            clocks: 1, ack: 1, exp_ack: 1, exp_to: 0};

    rst_n = 1'b0; rst_def = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; tx_valid_def = 1'b0; tx_data_def = 8'h00;
    dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_clk_oe", 32'(clk_oe), 32'(0));
    check("rst_data_oe", 32'(data_oe), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ack_ok", 32'(ack_ok), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));

    // Clock-inhibit length at default parameters.
    rst_def = 1'b1;
    @(negedge clk);
    tx_data_def  = PS2_CMD_SET_LEDS;
    tx_valid_def = 1'b1;
    @(negedge clk);
    tx_valid_def = 1'b0;
    n = 0; first_doe = 0;
    while (d_clk_oe && n < 2 * DEF_INH) begin
      n++;
      if (d_data_oe && first_doe == 0) first_doe = n;
      @(negedge clk);
    end
    check("inhibit_cycles", 32'(n), 32'(DEF_INH));
    check("inhibit_data_oe_last", 32'(first_doe), 32'(DEF_INH));
    check("start_data_oe", 32'(d_data_oe), 32'(1));
    rst_def = 1'b0;

    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      transfer(vecs[i].data, vecs[i].clocks, vecs[i].ack, 1'b0, vecs[i].exp_ack, vecs[i].exp_to);

    // Device clock activity while idle must not disturb the host outputs.
    changes = 0;
    for (int i = 0; i < 6; i++) begin
      dev_clk = ~dev_clk;
      repeat (20) begin
        @(negedge clk);
        if (clk_oe || data_oe || !tx_ready || done) changes++;
      end
    end
    dev_clk = 1'b1;
    check("idle_clocks_ignored", 32'(changes), 32'(0));

    // In-flight 0xED must survive a 0x55 request made while busy.
    transfer(PS2_CMD_SET_LEDS, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset after the fifth device clock edge.
    repeat (5) @(negedge clk);
    base     = done_cnt;
    tx_data  = PS2_CMD_SET_LEDS;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    device(1'b1, 1'b1, 5, frame, seen);
    repeat (5) @(negedge clk);
    check("reset_mid_ready", 32'(tx_ready), 32'(1));
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    rst_n    = 1'b1;
    repeat (50) @(negedge clk);
    check("reset_no_done", 32'(done_cnt - base), 32'(0));
    transfer(PS2_CMD_SET_LEDS, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Random bytes and ACK choices against the frame model.
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      a = 1'($urandom_range(0, 1));
      transfer(d, 1'b1, a, 1'b0, a, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the system clock frequency.
REQ-002 SHALL have parameter INHIBIT_US, default 100, meaning the PS/2 clock-inhibit time in microseconds.
REQ-003 SHALL have parameter TIMEOUT_MS, default 15, meaning the no-progress watchdog in milliseconds.
REQ-004 SHALL have port clk  in  1  system clock; all logic is on the rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port tx_data  in  8  command byte, for example 0xED (set LEDs).
REQ-007 SHALL have port tx_valid  in  1  request; a byte is accepted when tx_valid and tx_ready are both 1.
REQ-008 SHALL have port tx_ready  out  1  high only in IDLE.
REQ-009 SHALL have port ps2_clk_in / ps2_data_in  in  1 each  raw open-collector line levels (asynchronous).
REQ-010 SHALL have port ps2_clk_oe / ps2_data_oe  out  1 each  1 = drive the line low, 0 = release it (the pad is tristated externally).
REQ-011 SHALL have port done  out  1  one-cycle pulse at the end of every transfer.
REQ-012 SHALL have port ack_ok  out  1  valid with done: 1 = device ACK seen, 0 = NACK.
REQ-013 SHALL have port timeout  out  1  one-cycle pulse, coincident with done, when the watchdog expires.
REQ-014 SHALL have port busy  out  1  equal to the inverse of tx_ready.

Function
REQ-015 ps2_clk_in and ps2_data_in SHALL each pass through a 2-FF synchronizer; a falling edge of the PS/2 clock SHALL be detected from the synchronized samples (prev=1, cur=0).
REQ-016 The FSM SHALL have states IDLE, INHIBIT, START, SEND, WAIT_ACK, WAIT_IDLE and DONE.
REQ-017 IDLE SHALL behave as follows: both oe outputs are 0; on handshake, latch tx_data, compute the odd parity bit as ~^tx_data, clear the edge counter, and go to INHIBIT.
REQ-018 INHIBIT SHALL behave as follows: ps2_clk_oe=1 for CLK_HZ/1e6*INHIBIT_US cycles; ps2_data_oe is asserted in the final cycle; then go to START.
REQ-019 START SHALL behave as follows: ps2_clk_oe=0 and ps2_data_oe=1 (start bit 0); go to SEND the next cycle.
REQ-020 SEND SHALL behave as follows: on falling edges 1 to 8, drive data bit n-1 (LSB first; ps2_data_oe = ~bit); edge 9 drives parity; edge 10 releases data (stop bit 1); then go to WAIT_ACK.
REQ-021 WAIT_ACK SHALL sample synchronized data on the 11th falling edge, setting ack_ok_reg = ~data, then go to WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL wait until the synchronized clk and data are both 1, then go to DONE.
REQ-023 DONE SHALL pulse done for one cycle, then return to IDLE; tx_ready rises the following cycle.
REQ-024 The edge counter SHALL be 4 bits, SHALL count 0 to 11, and SHALL never wrap.
REQ-025 The watchdog SHALL reload on each state change and each falling edge; on expiry in any non-IDLE state, release both lines, pulse timeout, done and ack_ok=0 in one cycle, then go to IDLE.
REQ-026 tx_valid while busy SHALL be ignored and SHALL NOT be queued.
REQ-027 A falling edge detected during INHIBIT or START SHALL be ignored.
REQ-028 tx_data changes after acceptance SHALL have no effect on the byte in flight.
REQ-029 Device clock pulses while in IDLE SHALL leave the outputs unchanged, so the receiver can share the lines.
REQ-030 Worst-case latency from acceptance to done SHALL be INHIBIT + 11 device clocks + idle wait, or the timeout.

Reset
REQ-031 Asserting reset SHALL take effect asynchronously: state=IDLE, both oe=0, done=ack_ok=timeout=0, busy=0, tx_ready=1, counters and synchronizers at their idle values (sync=1).
REQ-032 Reset asserted mid-transfer SHALL release both lines immediately, with no done pulse.
REQ-033 After deassertion the block SHALL accept a byte in the first cycle that tx_valid=1.

Structure
REQ-034 The state enumeration, the PS/2 frame length (11) and the default command constants (0xED set-LEDs, 0xFF reset) SHALL live in a shared ps2_pkg package.
REQ-035 One sub-module ps2_sync_edge SHALL be instantiated per line and SHALL provide the 2-FF synchronizer and the fall-edge pulse; it is reusable by the existing keyboard receiver.
REQ-036 The inhibit and watchdog counters SHALL be sized with $clog2 of their terminal counts.

Verification
REQ-037 The bench SHALL cover: send 0xED, device model clocks at 12 kHz and ACKs -> bits 1,0,1,1,0,1,1,1, parity 1, stop released, done=1, ack_ok=1.
REQ-038 The bench SHALL cover: send 0x00, device holds data high on the 11th edge -> parity 1, done=1, ack_ok=0.
REQ-039 The bench SHALL cover: send 0xFF, device never clocks -> timeout, done and ack_ok=0 at TIMEOUT_MS, both oe=0, tx_ready=1.
REQ-040 The bench SHALL cover: INHIBIT duration -> ps2_clk_oe high for exactly 10_000 cycles at default parameters.
REQ-041 The bench SHALL cover: reset asserted after the 5th edge -> both oe=0 in the same cycle, no done, and a subsequent 0xED completes with ack_ok=1.
REQ-042 The bench SHALL cover: tx_valid pulsed with 0x55 while busy -> ignored, and the in-flight 0xED frame is unchanged.
